// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for the 3x3 window memory: one read burst of IMG_W*IMG_H
// windows, writes delayed by the filter latency, mem_done sequencing check.
module filter_frame_ctrl #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int LAT   = 4,
    parameter int CW    = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          mem_done,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          busy,
    output logic          frame_done,
    output logic          aborted,
    output logic          err,
    output logic [CW-1:0] rd_cnt,
    output logic [CW-1:0] wr_cnt,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_C = CW'(IMG_W * IMG_H - 1);

    state_t          state_r, state_s;
    logic            mem_rd_r, rd_s;
    logic [LAT-1:0]  sr_r, sr_s;
    logic [LAT:0]    sr_cat_s;
    logic            busy_r, frame_done_r, aborted_r, err_r, slot_r;
    logic            start_ok_s, abort_s, done_s, slot_s;
    logic [CW-1:0]   rd_cnt_r, wr_cnt_r;
    logic [15:0]     frame_cnt_r;

    assign mem_rd     = mem_rd_r;
    assign mem_wr     = sr_r[LAT-1];
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign aborted    = aborted_r;
    assign err        = err_r;
    assign rd_cnt     = rd_cnt_r;
    assign wr_cnt     = wr_cnt_r;
    assign frame_cnt  = frame_cnt_r;

    // Next-state, next read enable and delay-line shift; abort flushes the line.
    always_comb begin
        state_s    = state_r;
        rd_s       = 1'b0;
        sr_cat_s   = {sr_r, mem_rd_r};
        sr_s       = sr_cat_s[LAT-1:0];
        start_ok_s = 1'b0;
        abort_s    = 1'b0;
        done_s     = 1'b0;
        slot_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && !abort) begin
                    state_s    = S_READ;
                    rd_s       = 1'b1;
                    start_ok_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_s = S_IDLE;
                    abort_s = 1'b1;
                    sr_s    = '0;
                end else if (rd_cnt_r == LAST_C) begin
                    // This cycle carries the Nth read; mem_done is due next cycle.
                    state_s = S_DRAIN;
                    slot_s  = 1'b1;
                end else begin
                    rd_s = 1'b1;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_s = S_IDLE;
                    abort_s = 1'b1;
                    sr_s    = '0;
                end else if (sr_r[LAT-1] && (wr_cnt_r == LAST_C)) begin
                    state_s = S_DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                sr_s    = '0;
            end
        endcase
    end

    // State, enables, pulses, counters and sticky mem_done error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            mem_rd_r     <= 1'b0;
            sr_r         <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            aborted_r    <= 1'b0;
            slot_r       <= 1'b0;
            err_r        <= 1'b0;
            rd_cnt_r     <= '0;
            wr_cnt_r     <= '0;
            frame_cnt_r  <= 16'd0;
        end else begin
            state_r      <= state_s;
            mem_rd_r     <= rd_s;
            sr_r         <= sr_s;
            busy_r       <= (state_s != S_IDLE);
            frame_done_r <= done_s;
            aborted_r    <= abort_s;
            slot_r       <= slot_s;
            if (start_ok_s) begin
                rd_cnt_r <= '0;
                wr_cnt_r <= '0;
                err_r    <= 1'b0;
            end else begin
                rd_cnt_r <= rd_cnt_r + {{(CW-1){1'b0}}, mem_rd_r};
                wr_cnt_r <= wr_cnt_r + {{(CW-1){1'b0}}, sr_r[LAT-1]};
                if (busy_r && (mem_done != slot_r)) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
            end
            if (done_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Self-checking bench for filter_frame_ctrl (4x3 frame, latency 2) using a
// frame-offset reference model, directed scenarios and a random phase.
module tb_filter_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int L  = 2;
    localparam int CWT = 17;
    localparam int N  = W * H;

    logic            clk, rst_n, start, abort, mem_done;
    logic            mem_rd, mem_wr, busy, frame_done, aborted, err;
    logic [CWT-1:0]  rd_cnt, wr_cnt;
    logic [15:0]     frame_cnt;

    filter_frame_ctrl #(.IMG_W(W), .IMG_H(H), .LAT(L), .CW(CWT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mem_done(mem_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .frame_done(frame_done),
        .aborted(aborted), .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: t is the cycle offset from the accepted start.
    bit          act;
    int          t;
    bit          e_rd, e_wr, e_busy, e_fd, e_ab, e_err;
    int          e_rd_cnt, e_wr_cnt, e_fc;

    int  cnum, fd_cyc, rd_rise, wr_rise, err_rise;
    bit  prev_rd, prev_wr, prev_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        act = 1'b0; t = 0;
        e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_fd = 1'b0; e_ab = 1'b0; e_err = 1'b0;
        e_rd_cnt = 0; e_wr_cnt = 0; e_fc = 0;
    endtask

    task automatic model_step(input bit s, input bit a, input bit md);
        bit n_err;
        bit slot;
        slot  = act && (t == N + 1);
        n_err = e_err;
        if (e_busy && (md != slot)) n_err = 1'b1;
        e_rd_cnt += int'(e_rd);
        e_wr_cnt += int'(e_wr);
        e_ab = 1'b0;
        if (!act) begin
            if (s && !a) begin
                act = 1'b1; t = 1; e_rd_cnt = 0; e_wr_cnt = 0; n_err = 1'b0;
            end
        end else if (a && (t <= N + L)) begin
            act = 1'b0; e_ab = 1'b1;
        end else if (t == N + L + 1) begin
            act = 1'b0;
        end else begin
            t++;
        end
        e_err  = n_err;
        e_rd   = act && (t <= N);
        e_wr   = act && (t >= L + 1) && (t <= N + L);
        e_busy = act;
        e_fd   = act && (t == N + L + 1);
        if (e_fd) e_fc = (e_fc + 1) % 65536;
    endtask

    task automatic check_all();
        chk("mem_rd",     32'(mem_rd),     32'(e_rd));
        chk("mem_wr",     32'(mem_wr),     32'(e_wr));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("aborted",    32'(aborted),    32'(e_ab));
        chk("err",        32'(err),        32'(e_err));
        chk("rd_cnt",     32'(rd_cnt),     32'(e_rd_cnt));
        chk("wr_cnt",     32'(wr_cnt),     32'(e_wr_cnt));
        chk("frame_cnt",  32'(frame_cnt),  32'(e_fc));
    endtask

    // mdm: 0 well-behaved memory, 1 withheld, 2 forced high, 3 random glitches
    task automatic cyc(input bit s, input bit a, input int mdm);
        bit md_norm, md;
        md_norm = act && (t == N + 1);
        case (mdm)
            0:       md = md_norm;
            1:       md = 1'b0;
            2:       md = 1'b1;
            default: md = ($urandom_range(0, 99) < 3) ? !md_norm : md_norm;
        endcase
        start = s; abort = a; mem_done = md;
        @(posedge clk);
        #1;
        cnum++;
        model_step(s, a, md);
        check_all();
        if (mem_rd && !prev_rd) rd_rise = cnum;
        if (mem_wr && !prev_wr) wr_rise = cnum;
        if (err && !prev_err) err_rise = cnum;
        if (frame_done) fd_cyc = cnum;
        prev_rd = mem_rd; prev_wr = mem_wr; prev_err = err;
    endtask

    task automatic mark();
        cnum = 0; fd_cyc = -1; rd_rise = -1; wr_rise = -1; err_rise = -1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"},   32'(mem_rd),    32'd0);
        chk({tag, "_wr"},   32'(mem_wr),    32'd0);
        chk({tag, "_busy"}, 32'(busy),      32'd0);
        chk({tag, "_rdc"},  32'(rd_cnt),    32'd0);
        chk({tag, "_fc"},   32'(frame_cnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_done = 1'b0;
        prev_rd = 1'b0; prev_wr = 1'b0; prev_err = 1'b0;
        model_reset();
        mark();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);

        // Nominal frame
        mark();
        cyc(1'b1, 1'b0, 0);
        repeat (15) cyc(1'b0, 1'b0, 0);
        chk("nom_rd_rise", 32'(rd_rise), 32'd1);
        chk("nom_wr_rise", 32'(wr_rise), 32'd3);
        chk("nom_fd_cyc",  32'(fd_cyc),  32'd15);
        chk("nom_rd_cnt",  32'(rd_cnt),  32'd12);
        chk("nom_wr_cnt",  32'(wr_cnt),  32'd12);
        chk("nom_fc",      32'(frame_cnt), 32'd1);
        chk("nom_err",     32'(err),     32'd0);

        // Back-to-back frames with start held
        mark();
        repeat (32) cyc(1'b1, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);
        chk("b2b_rise2", 32'(rd_rise), 32'd17);
        chk("b2b_fd2",   32'(fd_cyc),  32'd31);
        chk("b2b_fc",    32'(frame_cnt), 32'd3);

        // Abort sampled in READ cycle 5
        mark();
        cyc(1'b1, 1'b0, 0);
        repeat (4) cyc(1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 0);
        chk("abt_aborted", 32'(aborted), 32'd1);
        chk("abt_rd",      32'(mem_rd),  32'd0);
        chk("abt_wr",      32'(mem_wr),  32'd0);
        chk("abt_busy",    32'(busy),    32'd0);
        chk("abt_rd_cnt",  32'(rd_cnt),  32'd5);
        chk("abt_wr_cnt",  32'(wr_cnt),  32'd3);
        repeat (3) cyc(1'b0, 1'b1, 0);
        chk("abt_fd",      32'(fd_cyc),  32'hFFFF_FFFF);
        chk("abt_fc",      32'(frame_cnt), 32'd3);

        // mem_done withheld
        mark();
        cyc(1'b1, 1'b0, 1);
        repeat (15) cyc(1'b0, 1'b0, 1);
        chk("wh_err_rise", 32'(err_rise), 32'd14);
        chk("wh_fd_cyc",   32'(fd_cyc),   32'd15);
        cyc(1'b0, 1'b0, 0);

        // New start clears err; then mem_done injected in cycle 4
        mark();
        cyc(1'b1, 1'b0, 0);
        chk("clr_err", 32'(err), 32'd0);
        repeat (3) cyc(1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 2);
        chk("inj_err_rise", 32'(err_rise), 32'd5);
        repeat (11) cyc(1'b0, 1'b0, 0);
        chk("inj_fd_cyc", 32'(fd_cyc), 32'd15);
        cyc(1'b0, 1'b0, 0);

        // Asynchronous reset in DRAIN (cycle 13)
        mark();
        cyc(1'b1, 1'b0, 0);
        repeat (12) cyc(1'b0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        prev_rd = 1'b0; prev_wr = 1'b0; prev_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mark();
        cyc(1'b1, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);
        chk("rst_rd_cnt1", 32'(rd_cnt), 32'd1);
        repeat (14) cyc(1'b0, 1'b0, 0);
        chk("rst_fd_cyc", 32'(fd_cyc), 32'd15);
        chk("rst_fc",     32'(frame_cnt), 32'd1);

        // Random start/abort/mem_done traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0), 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
